// File: rtl/cordic_range_reducer.sv
// cordic_range_reducer: folds a circular-mode angle into [-pi/2, +pi/2] ahead of CORDIC rotation.
// Define CORDIC_RR_SATURATE_EN to saturate the x/y negation and report it on sat_flag.
module cordic_range_reducer #(
  parameter int W = 32,
  parameter int FRAC_BITS = 16,
  parameter int PI_Q = 205887,
  parameter int MAX_WRAP = 8192,
  parameter logic [1:0] CIRCULAR = 2'b01
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  input  logic [W-1:0] angle_in,
  input  logic [1:0]   mode_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic [W-1:0] angle_out,
  output logic [1:0]   mode_out,
  output logic         folded,
  output logic         wrap_err,
  output logic         sat_flag
);
  localparam int CW = $clog2(MAX_WRAP + 1);
  localparam logic [1:0] IDLE = 2'd0, WRAP = 2'd1, FOLD = 2'd2, DONE = 2'd3;
  localparam logic signed [W-1:0] PI = W'(PI_Q);
  localparam logic signed [W-1:0] HALF = PI >>> 1;
  localparam logic signed [W-1:0] TWO = PI <<< 1;
  localparam logic signed [W-1:0] NPI = -PI;
  localparam logic signed [W-1:0] NHALF = -HALF;
  localparam logic signed [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MAX = ~MIN;
  if (FRAC_BITS >= W) begin : g_bad_frac
    $error("FRAC_BITS must be smaller than W");
  end
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic signed [W-1:0] x_r, y_r, a_r, nx, ny;
  logic sat_n, sat_r, fold_r, err_r, ov_r;
  logic [1:0] mode_r;
  always_comb begin
`ifdef CORDIC_RR_SATURATE_EN
    nx = (x_r == MIN) ? MAX : -x_r;
    ny = (y_r == MIN) ? MAX : -y_r;
    sat_n = (x_r == MIN) || (y_r == MIN);
`else
    nx = -x_r;
    ny = -y_r;
    sat_n = 1'b0;
`endif
  end
  // out_valid is registered so pass-through tuples still cost one cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      x_r <= '0;
      y_r <= '0;
      a_r <= '0;
      mode_r <= 2'b00;
      fold_r <= 1'b0;
      err_r <= 1'b0;
      sat_r <= 1'b0;
      ov_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x_r <= x_in;
          y_r <= y_in;
          a_r <= angle_in;
          mode_r <= mode_in;
          cnt <= '0;
          fold_r <= 1'b0;
          err_r <= 1'b0;
          sat_r <= 1'b0;
          state <= (mode_in == CIRCULAR) ? WRAP : DONE;
        end
        WRAP: if (a_r > PI || a_r < NPI) begin
          if (cnt == CW'(MAX_WRAP)) begin
            err_r <= 1'b1;
            state <= FOLD;
          end else begin
            a_r <= (a_r > PI) ? a_r - TWO : a_r + TWO;
            cnt <= cnt + 1'b1;
          end
        end else state <= FOLD;
        FOLD: begin
          if (a_r > HALF || a_r < NHALF) begin
            a_r <= (a_r > HALF) ? a_r - PI : a_r + PI;
            x_r <= nx;
            y_r <= ny;
            fold_r <= 1'b1;
            sat_r <= sat_n;
          end
          ov_r <= 1'b1;
          state <= DONE;
        end
        default: if (ov_r && out_ready) begin
          ov_r <= 1'b0;
          state <= IDLE;
        end else ov_r <= 1'b1;
      endcase
    end
  end
  assign in_ready = state == IDLE;
  assign out_valid = ov_r;
  assign x_out = x_r;
  assign y_out = y_r;
  assign angle_out = a_r;
  assign mode_out = mode_r;
  assign folded = fold_r;
  assign wrap_err = err_r;
  assign sat_flag = sat_r;
endmodule
